// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating stall counter for performance debug.
module id_ex_stage #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  hold,
   input  logic                  Jump_i,
   input  logic                  RegDst_i,
   input  logic                  BranchEQ_i,
   input  logic                  BranchNE_i,
   input  logic                  MemRead_i,
   input  logic                  MemtoReg_i,
   input  logic                  MemWrite_i,
   input  logic                  ALUSrc_i,
   input  logic                  RegWrite_i,
   input  logic                  JR_i,
   input  logic [3:0]            ALUOp_i,
   input  logic [DATA_WIDTH-1:0] PC4_i,
   input  logic [DATA_WIDTH-1:0] ReadData1_i,
   input  logic [DATA_WIDTH-1:0] ReadData2_i,
   input  logic [DATA_WIDTH-1:0] Imm_i,
   input  logic [ADDR_WIDTH-1:0] Rs_i,
   input  logic [ADDR_WIDTH-1:0] Rt_i,
   input  logic [ADDR_WIDTH-1:0] Rd_i,
   input  logic [ADDR_WIDTH-1:0] Shamt_i,
   input  logic [5:0]            Funct_i,
   output logic                  Jump_o,
   output logic                  RegDst_o,
   output logic                  BranchEQ_o,
   output logic                  BranchNE_o,
   output logic                  MemRead_o,
   output logic                  MemtoReg_o,
   output logic                  MemWrite_o,
   output logic                  ALUSrc_o,
   output logic                  RegWrite_o,
   output logic                  JR_o,
   output logic [3:0]            ALUOp_o,
   output logic [DATA_WIDTH-1:0] PC4_o,
   output logic [DATA_WIDTH-1:0] ReadData1_o,
   output logic [DATA_WIDTH-1:0] ReadData2_o,
   output logic [DATA_WIDTH-1:0] Imm_o,
   output logic [ADDR_WIDTH-1:0] Rs_o,
   output logic [ADDR_WIDTH-1:0] Rt_o,
   output logic [ADDR_WIDTH-1:0] Rd_o,
   output logic [ADDR_WIDTH-1:0] Shamt_o,
   output logic [5:0]            Funct_o,
   output logic                  Valid_o,
   output logic                  Stall_o,
   output logic [CNT_WIDTH-1:0]  StallCount_o
);

   localparam int unsigned CtrlW = 14;
   localparam int unsigned DataW = 4 * DATA_WIDTH + 4 * ADDR_WIDTH + 6;
   localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CtrlW-1:0]     ctrl_in, ctrl_d, ctrl_q;
   logic [DataW-1:0]     data_in, data_d, data_q;
   logic                 valid_d, valid_q;
   logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
   logic                 load_use;

   assign ctrl_in = {ALUOp_i, Jump_i, RegDst_i, BranchEQ_i, BranchNE_i, MemRead_i, MemtoReg_i,
                     MemWrite_i, ALUSrc_i, RegWrite_i, JR_i};
   assign data_in = {PC4_i, ReadData1_i, ReadData2_i, Imm_i, Rs_i, Rt_i, Rd_i, Shamt_i, Funct_i};

   assign {ALUOp_o, Jump_o, RegDst_o, BranchEQ_o, BranchNE_o, MemRead_o, MemtoReg_o,
           MemWrite_o, ALUSrc_o, RegWrite_o, JR_o} = ctrl_q;
   assign {PC4_o, ReadData1_o, ReadData2_o, Imm_o, Rs_o, Rt_o, Rd_o, Shamt_o, Funct_o} = data_q;
   assign Valid_o      = valid_q;
   assign StallCount_o = cnt_q;

   // A bubble (valid_q = 0) can never stall, so each load costs at most one stall cycle.
   assign load_use = valid_q & MemRead_o & (Rt_o != '0) & ((Rt_o == Rs_i) | (Rt_o == Rt_i));
   assign Stall_o  = load_use & ~hold;

   always_comb begin
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (!hold) begin
         data_d = data_in;
         if (flush || Stall_o) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            // Flush wins over a simultaneous stall and is not counted.
            if (!flush && cnt_q != CntMax) begin
               cnt_d = cnt_q + CntOne;
            end
         end else begin
            ctrl_d  = ctrl_in;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a behavioural model pushes the expected stage
// contents into a queue as each cycle is driven; they are popped after the edge.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   // ctrl bit layout: {ALUOp[3:0], Jump, RegDst, BEQ, BNE, MemRead, MemtoReg, MemWrite,
   //                   ALUSrc, RegWrite, JR}
   localparam logic [13:0] C_JR   = 14'h001;
   localparam logic [13:0] C_RW   = 14'h002;
   localparam logic [13:0] C_ASRC = 14'h004;
   localparam logic [13:0] C_MW   = 14'h008;
   localparam logic [13:0] C_M2R  = 14'h010;
   localparam logic [13:0] C_MR   = 14'h020;
   localparam logic [13:0] C_BEQ  = 14'h080;
   localparam logic [13:0] C_RDST = 14'h100;
   localparam logic [13:0] C_LW   = C_MR | C_M2R | C_RW | C_ASRC;
   localparam logic [13:0] C_ADD  = C_RW | C_RDST | 14'h0800;
   localparam logic [13:0] C_ADDI = C_RW | C_ASRC | 14'h1000;
   localparam logic [13:0] C_BEQI = C_BEQ | 14'h0400;

   typedef struct packed {
      logic [13:0]   ctrl;
      logic [DW-1:0] pc4;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [DW-1:0] imm;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] rd;
      logic [AW-1:0] sh;
      logic [5:0]    funct;
   } fields_t;

   typedef struct packed {
      fields_t       f;
      logic          valid;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic    reset, flush, hold;
   fields_t in_s, out_s;
   logic    o_jump, o_regdst, o_beq, o_bne, o_memread, o_memtoreg, o_memwrite, o_alusrc;
   logic    o_regwrite, o_jr, valid_o, stall_o;
   logic [3:0]    o_aluop;
   logic [DW-1:0] o_pc4, o_rd1, o_rd2, o_imm;
   logic [AW-1:0] o_rs, o_rt, o_rd, o_sh;
   logic [5:0]    o_funct;
   logic [CW-1:0] cnt_o;

   assign out_s = {o_aluop, o_jump, o_regdst, o_beq, o_bne, o_memread, o_memtoreg, o_memwrite,
                   o_alusrc, o_regwrite, o_jr, o_pc4, o_rd1, o_rd2, o_imm, o_rs, o_rt, o_rd, o_sh,
                   o_funct};

   id_ex_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .hold(hold),
      .Jump_i(in_s.ctrl[9]), .RegDst_i(in_s.ctrl[8]), .BranchEQ_i(in_s.ctrl[7]),
      .BranchNE_i(in_s.ctrl[6]), .MemRead_i(in_s.ctrl[5]), .MemtoReg_i(in_s.ctrl[4]),
      .MemWrite_i(in_s.ctrl[3]), .ALUSrc_i(in_s.ctrl[2]), .RegWrite_i(in_s.ctrl[1]),
      .JR_i(in_s.ctrl[0]), .ALUOp_i(in_s.ctrl[13:10]),
      .PC4_i(in_s.pc4), .ReadData1_i(in_s.rd1), .ReadData2_i(in_s.rd2), .Imm_i(in_s.imm),
      .Rs_i(in_s.rs), .Rt_i(in_s.rt), .Rd_i(in_s.rd), .Shamt_i(in_s.sh), .Funct_i(in_s.funct),
      .Jump_o(o_jump), .RegDst_o(o_regdst), .BranchEQ_o(o_beq), .BranchNE_o(o_bne),
      .MemRead_o(o_memread), .MemtoReg_o(o_memtoreg), .MemWrite_o(o_memwrite),
      .ALUSrc_o(o_alusrc), .RegWrite_o(o_regwrite), .JR_o(o_jr), .ALUOp_o(o_aluop),
      .PC4_o(o_pc4), .ReadData1_o(o_rd1), .ReadData2_o(o_rd2), .Imm_o(o_imm),
      .Rs_o(o_rs), .Rt_o(o_rt), .Rd_o(o_rd), .Shamt_o(o_sh), .Funct_o(o_funct),
      .Valid_o(valid_o), .Stall_o(stall_o), .StallCount_o(cnt_o)
   );

   int   tests = 0;
   int   fails = 0;
   exp_t model;
   logic known = 1'b0;
   exp_t sb_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic fields_t mk(input logic [13:0] ctrl, input logic [AW-1:0] rs,
                                  input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                                  input logic [DW-1:0] imm);
      fields_t f;
      f.ctrl  = ctrl;
      f.pc4   = $urandom;
      f.rd1   = $urandom;
      f.rd2   = $urandom;
      f.imm   = imm;
      f.rs    = rs;
      f.rt    = rt;
      f.rd    = rd;
      f.sh    = AW'($urandom);
      f.funct = 6'($urandom);
      return f;
   endfunction

   function automatic fields_t rnd();
      fields_t f;
      f = mk(14'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), $urandom);
      return f;
   endfunction

   // Model one cycle: check Stall_o before the edge, then compare the captured stage.
   task automatic tick(input string tag);
      exp_t nx, got;
      logic st;
      #1;
      st = model.valid & model.f.ctrl[5] & (model.f.rt != '0) &
           ((model.f.rt == in_s.rs) | (model.f.rt == in_s.rt)) & ~hold;
      if (known) chk({tag, "_stall"}, 32'(stall_o), 32'(st));
      if (!reset) begin
         nx = '0;
      end else if (hold) begin
         nx = model;
      end else begin
         nx.f   = in_s;
         nx.cnt = model.cnt;
         if (flush || st) begin
            nx.f.ctrl = '0;
            nx.valid  = 1'b0;
            if (!flush && model.cnt != 4'hF) nx.cnt = model.cnt + 4'd1;
         end else begin
            nx.valid = 1'b1;
         end
      end
      sb_q.push_back(nx);
      model = nx;
      known = 1'b1;
      @(posedge clk);
      #1;
      got = {out_s, valid_o, cnt_o};
      tests++;
      if (sb_q.size() == 0) begin
         fails++;
         $error("FAIL %s: got output with no expected entry", tag);
      end else begin
         exp_t w;
         w = sb_q.pop_front();
         assert (got === w) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, w);
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      hold  = 1'b0;
      in_s  = rnd();
      tick("reset0");
      in_s = rnd();
      tick("reset1");
      chk("reset_valid", 32'(valid_o), 32'd0);
      chk("reset_cnt", 32'(cnt_o), 32'd0);

      reset = 1'b1;
      in_s  = mk(C_ADDI, 5'd3, 5'd9, 5'd0, 32'h0000_0005);
      tick("addi");
      chk("addi_valid", 32'(valid_o), 32'd1);
      chk("addi_imm", o_imm, 32'h0000_0005);
      chk("addi_aluop", 32'(o_aluop), 32'h4);

      in_s = mk(C_LW, 5'd2, 5'd8, 5'd0, 32'h10);
      tick("lw8");
      in_s = mk(C_ADD, 5'd8, 5'd10, 5'd11, 32'h0);
      tick("use8_stall");
      chk("use8_stall_seen", 32'(stall_o), 32'd0);
      chk("bubble_regwrite", 32'(o_regwrite), 32'd0);
      chk("bubble_valid", 32'(valid_o), 32'd0);
      chk("bubble_cnt", 32'(cnt_o), 32'd1);
      tick("use8_capture");
      chk("use8_rs", 32'(o_rs), 32'd8);
      chk("use8_valid", 32'(valid_o), 32'd1);

      in_s = mk(C_LW, 5'd4, 5'd0, 5'd0, 32'h20);
      tick("lw0");
      in_s = mk(C_ADD, 5'd0, 5'd0, 5'd7, 32'h0);
      tick("use0");
      in_s = mk(C_ADD, 5'd5, 5'd12, 5'd8, 32'h0);
      tick("add_rd8");
      in_s = mk(C_ADD, 5'd8, 5'd13, 5'd14, 32'h0);
      tick("use_rd8");

      in_s = mk(C_LW, 5'd2, 5'd8, 5'd0, 32'h30);
      tick("lw8_f");
      in_s  = mk(C_ADD, 5'd8, 5'd8, 5'd3, 32'h0);
      flush = 1'b1;
      tick("flush_vs_stall");
      chk("flush_cnt", 32'(cnt_o), 32'd1);
      in_s = mk(C_BEQI, 5'd1, 5'd2, 5'd0, 32'h4);
      tick("flush_beq");
      chk("flush_beq_o", 32'(o_beq), 32'd0);
      flush = 1'b0;

      in_s = mk(C_LW, 5'd6, 5'd8, 5'd0, 32'h40);
      tick("lw8_h");
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_s    = rnd();
         in_s.rs = 5'd8;
         tick("hold");
         chk("hold_rt", 32'(o_rt), 32'd8);
      end
      hold = 1'b0;
      tick("unhold_stall");
      chk("unhold_cnt", 32'(cnt_o), 32'd2);

      reset = 1'b0;
      tick("reset_pre_sat");
      reset = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_s = mk(C_LW, 5'd1, 5'd8, 5'd0, 32'($urandom));
         tick("sat_lw");
         in_s = mk(C_ADD, 5'd9, 5'd8, 5'd2, 32'h0);
         tick("sat_use");
         if (i == 14) chk("sat_at15", 32'(cnt_o), 32'hF);
      end
      chk("sat_final", 32'(cnt_o), 32'hF);

      in_s = mk(C_LW, 5'd1, 5'd8, 5'd0, 32'h50);
      tick("lw_mid");
      in_s = mk(C_ADD, 5'd8, 5'd3, 5'd4, 32'h0);
      #1;
      chk("mid_stall_high", 32'(stall_o), 32'd1);
      reset = 1'b0;
      tick("reset_mid_stall");
      chk("mid_stall_drop", 32'(stall_o), 32'd0);
      chk("mid_cnt", 32'(cnt_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
